// File: rtl/ray_dir_gen_pkg.sv
// ---------------------------------------------------------------------------
// ray_dir_gen_pkg
// Purpose : shared types and constants for the per-pixel ray direction
//           generator: FSM state encoding, direction/magnitude widths,
//           raster size defaults and the {x, y} direction packing helper.
// ---------------------------------------------------------------------------
package ray_dir_gen_pkg;

  localparam int DIR_W     = 11;   // signed width of each direction component
  localparam int D_W       = 8;    // target magnitude width
  localparam int CNT_W     = 10;   // column / row counter width (up to 1024)
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The normalizer expects x in the upper half and y in the lower half.
  function automatic logic [2*DIR_W-1:0] pack_dir(input logic [DIR_W-1:0] x,
                                                  input logic [DIR_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/ray_dir_gen_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Purpose : column/row raster counter with wrap at the end of each line.
// Ports   : clk, rst_n      - clock, async active-low reset
//           i_clear         - restart at (0,0); has priority over i_advance
//           i_advance       - step one pixel (col wraps into row)
//           o_col_nxt/o_row_nxt - position the counter takes at the next edge
//           o_last          - current position is the final pixel of a frame
// ---------------------------------------------------------------------------
module raster_counter
  import ray_dir_gen_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [CNT_W-1:0] o_col_nxt,
  output logic [CNT_W-1:0] o_row_nxt,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(H_RES - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(V_RES - 1);

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  // Next position: clear, step with line wrap, or hold.
  always_comb begin
    o_col_nxt = r_col;
    o_row_nxt = r_row;
    if (i_clear) begin
      o_col_nxt = {CNT_W{1'b0}};
      o_row_nxt = {CNT_W{1'b0}};
    end else if (i_advance) begin
      if (r_col == COL_MAX) begin
        o_col_nxt = {CNT_W{1'b0}};
        if (r_row == ROW_MAX) begin
          o_row_nxt = {CNT_W{1'b0}};
        end else begin
          o_row_nxt = r_row + CNT_W'(1);
        end
      end else begin
        o_col_nxt = r_col + CNT_W'(1);
        o_row_nxt = r_row;
      end
    end else begin
      o_col_nxt = r_col;
      o_row_nxt = r_row;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= {CNT_W{1'b0}};
      r_row <= {CNT_W{1'b0}};
    end else begin
      r_col <= o_col_nxt;
      r_row <= o_row_nxt;
    end
  end

  assign o_last = (r_col == COL_MAX) && (r_row == ROW_MAX);

endmodule

// File: rtl/ray_dir_gen.sv
// ---------------------------------------------------------------------------
// ray_dir_gen
// Purpose : walks the screen raster once per start request and emits, per
//           pixel, a camera-space ray direction {x, y} (centered on the
//           screen middle, y up) plus the latched magnitude d, over a
//           valid/ready handshake towards the normalizer.
// Ports   : clk, rst_n          - clock, async active-low reset
//           start, abort, d_in  - frame request, cancel, target magnitude
//           out_ready           - downstream accepts current vector
//           out_valid, dir, d, pix_x, pix_y, sof, eol, eof - vector stream
//           busy, frame_done    - status (RUN/DONE, end-of-frame pulse)
// All outputs come straight from flops; out_ready only feeds next-state logic.
// ---------------------------------------------------------------------------
module ray_dir_gen
  import ray_dir_gen_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [D_W-1:0]     d_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [2*DIR_W-1:0] dir,
  output logic [D_W-1:0]     d,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               busy,
  output logic               frame_done
);

  state_e             r_state;
  logic [D_W-1:0]     r_d;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_out_valid;
  logic [2*DIR_W-1:0] r_dir;
  logic [CNT_W-1:0]   r_pix_x;
  logic [CNT_W-1:0]   r_pix_y;
  logic               r_sof;
  logic               r_eol;
  logic               r_eof;

  logic               w_xfer;
  logic               w_start_ok;
  logic               w_run_ok;
  logic               w_advance;
  logic               w_emit;
  logic               w_last;
  logic [CNT_W-1:0]   w_col_nxt;
  logic [CNT_W-1:0]   w_row_nxt;
  logic [DIR_W-1:0]   w_dir_x;
  logic [DIR_W-1:0]   w_dir_y;

  assign w_xfer     = r_out_valid & out_ready;
  assign w_start_ok = (r_state == ST_IDLE) & start & ~abort;
  assign w_run_ok   = (r_state == ST_RUN) & ~abort;
  // The last pixel never wraps, and an aborted transfer never advances.
  assign w_advance  = w_run_ok & w_xfer & ~w_last;
  // A vector is presented next cycle on a fresh start or while RUN continues.
  assign w_emit     = w_start_ok | (w_run_ok & ~(w_xfer & w_last));

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_start_ok),
    .i_advance (w_advance),
    .o_col_nxt (w_col_nxt),
    .o_row_nxt (w_row_nxt),
    .o_last    (w_last)
  );

  // Directions for the upcoming position, so they land in flops alongside it.
  assign w_dir_x = {1'b0, w_col_nxt} - DIR_W'(H_RES / 2);
  assign w_dir_y = DIR_W'(V_RES / 2) - {1'b0, w_row_nxt};

  // Frame FSM with its status outputs and the latched magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_d          <= {D_W{1'b0}};
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state <= ST_RUN;
            r_d     <= d_in;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_xfer && w_last) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b1;
            r_frame_done <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Vector stream registers; reloading unchanged values while stalled keeps them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dir       <= {(2*DIR_W){1'b0}};
      r_pix_x     <= {CNT_W{1'b0}};
      r_pix_y     <= {CNT_W{1'b0}};
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_dir       <= pack_dir(w_dir_x, w_dir_y);
      r_pix_x     <= w_col_nxt;
      r_pix_y     <= w_row_nxt;
      r_sof       <= (w_col_nxt == CNT_W'(0)) && (w_row_nxt == CNT_W'(0));
      r_eol       <= (w_col_nxt == CNT_W'(H_RES - 1));
      r_eof       <= (w_col_nxt == CNT_W'(H_RES - 1)) && (w_row_nxt == CNT_W'(V_RES - 1));
    end else begin
      r_out_valid <= 1'b0;
      r_dir       <= {(2*DIR_W){1'b0}};
      r_pix_x     <= {CNT_W{1'b0}};
      r_pix_y     <= {CNT_W{1'b0}};
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign dir        = r_dir;
  assign d          = r_d;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign sof        = r_sof;
  assign eol        = r_eol;
  assign eof        = r_eof;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ray_dir_gen.sv
// ---------------------------------------------------------------------------
// tb_ray_dir_gen
// Directed bench for ray_dir_gen on a 4x2 raster. Expected directions are a
// hand-computed table: dir_x = col - 2, dir_y = 1 - row, packed {x, y}.
// ---------------------------------------------------------------------------
module tb_ray_dir_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  d_in;
  logic        out_ready;
  logic        out_valid;
  logic [21:0] dir;
  logic [7:0]  d;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        sof;
  logic        eol;
  logic        eof;
  logic        busy;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Pixel index i = row*4 + col.
  logic [21:0] dir_tab [8] = '{22'h3FF001, 22'h3FF801, 22'h000001, 22'h000801,
                               22'h3FF000, 22'h3FF800, 22'h000000, 22'h000800};

  ray_dir_gen #(.H_RES(4), .V_RES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .d_in       (d_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .dir        (dir),
    .d          (d),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full check of the vector for pixel index i.
  task automatic chk_px(input string tag, input int i);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_x"}, {22'd0, pix_x}, i % 4);
    chk({tag, "_y"}, {22'd0, pix_y}, i / 4);
    chk({tag, "_dir"}, {10'd0, dir}, {10'd0, dir_tab[i]});
    chk({tag, "_sof"}, {31'd0, sof}, (i == 0) ? 32'd1 : 32'd0);
    chk({tag, "_eol"}, {31'd0, eol}, (i % 4 == 3) ? 32'd1 : 32'd0);
    chk({tag, "_eof"}, {31'd0, eof}, (i == 7) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; d_in = 8'd0; out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dir", {10'd0, dir}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Full frame with out_ready held high.
    start = 1'b1; d_in = 8'd100; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("f1_d", {24'd0, d}, 32'd100);
    chk("f1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk_px($sformatf("f1_p%0d", i), i);
      chk("f1_nofdone", {31'd0, frame_done}, 32'd0);
      step();
    end
    chk("f1_fdone", {31'd0, frame_done}, 32'd1);
    chk("f1_done_valid", {31'd0, out_valid}, 32'd0);
    chk("f1_done_busy", {31'd0, busy}, 32'd1);
    step();
    chk("f1_fdone_end", {31'd0, frame_done}, 32'd0);
    chk("f1_idle_busy", {31'd0, busy}, 32'd0);

    // Back-pressure at (1,0), then row wrap, then abort at (2,1).
    start = 1'b1;
    step();
    start = 1'b0;
    chk_px("bp_p0", 0);
    step();
    chk_px("bp_p1", 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_dir", {10'd0, dir}, 32'h3FF801);
      chk("bp_hold_x", {22'd0, pix_x}, 32'd1);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk_px("bp_p2", 2);
    step();
    chk_px("wrap_p3", 3);
    step();
    chk_px("wrap_p4", 4);
    step();
    step();
    chk_px("ab_p6", 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", {31'd0, out_valid}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("ab_nofdone", {31'd0, frame_done}, 32'd0);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk_px("ab_restart", 0);

    // Reset mid-frame at (1,1).
    for (int k = 0; k < 5; k++) step();
    chk_px("mr_p5", 5);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_dir", {10'd0, dir}, 32'd0);
    chk("mr_x", {22'd0, pix_x}, 32'd0);
    chk("mr_y", {22'd0, pix_y}, 32'd0);
    chk("mr_d", {24'd0, d}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_fdone", {31'd0, frame_done}, 32'd0);
    #2;
    rst_n = 1'b1;
    start = 1'b1; d_in = 8'd55;
    step();
    start = 1'b0;
    chk_px("mr_start", 0);
    chk("mr_start_d", {24'd0, d}, 32'd55);
    for (int k = 0; k < 8; k++) step();
    chk("mr_fdone_end", {31'd0, frame_done}, 32'd1);

    // Start while busy is ignored; start with abort in IDLE stays idle.
    step();
    start = 1'b1;
    step();
    chk_px("sb_p0", 0);
    step();
    chk("sb_ignored_x", {22'd0, pix_x}, 32'd1);
    abort = 1'b1;
    step();
    chk("sa_busy0", {31'd0, busy}, 32'd0);
    step();
    chk("sa_busy1", {31'd0, busy}, 32'd0);
    chk("sa_valid", {31'd0, out_valid}, 32'd0);
    start = 1'b0; abort = 1'b0;
    step();
    chk("sa_busy2", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
